// File: rtl/matmul_tile_sequencer.sv
// Control FSM for the BRAM-backed systolic matrix multiplier: walks every output
// tile, streams K paired input/weight reads per tile, waits for the result, writes it.
module matmul_tile_sequencer #(
  parameter int BLOCK_SIZE        = 2,
  parameter int CHUNK_SIZE        = 4,
  parameter int INNER_DIMENSION   = 256,
  parameter int W_OUTER_DIMENSION = 64,
  parameter int I_OUTER_DIMENSION = 2754,
  localparam int K    = INNER_DIMENSION / CHUNK_SIZE,
  localparam int NT_W = W_OUTER_DIMENSION / BLOCK_SIZE,
  localparam int NT_I = I_OUTER_DIMENSION / BLOCK_SIZE,
  localparam int WA_W = (NT_W * K > 1) ? $clog2(NT_W * K) : 1,
  localparam int IA_W = (NT_I * K > 1) ? $clog2(NT_I * K) : 1,
  localparam int OA_W = (NT_I * NT_W > 1) ? $clog2(NT_I * NT_W) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            start,
  output logic            ready,
  output logic            done,
  output logic            w_rd_en,
  output logic [WA_W-1:0] w_rd_addr,
  output logic            in_rd_en,
  output logic [IA_W-1:0] in_rd_addr,
  input  logic            mm_ready,
  output logic            mm_valid,
  output logic            mm_first,
  output logic            mm_last,
  input  logic            mm_done,
  output logic            out_wr_en,
  output logic [OA_W-1:0] out_wr_addr,
  output logic            proto_err,
  output logic [2:0]      dbg_state
);

  localparam int K_W  = (K > 1) ? $clog2(K) : 1;
  localparam int TW_W = (NT_W > 1) ? $clog2(NT_W) : 1;
  localparam int TI_W = (NT_I > 1) ? $clog2(NT_I) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  logic [2:0]      r_state;
  logic [K_W-1:0]  r_k;
  logic [TW_W-1:0] r_tw;
  logic [TI_W-1:0] r_ti;
  logic            r_pending;
  logic            r_proto_err;
  logic            r_ready;
  logic            r_done;
  logic            r_rd_en;
  logic            r_rd_first;
  logic            r_rd_last;
  logic [WA_W-1:0] r_w_addr;
  logic [IA_W-1:0] r_in_addr;
  logic            r_mm_valid;
  logic            r_mm_first;
  logic            r_mm_last;
  logic            r_wr_en;
  logic [OA_W-1:0] r_out_addr;

  logic            w_issue;
  logic            w_k_last;
  logic            w_tw_last;
  logic            w_ti_last;
  logic            w_wait_go;
  logic            w_capture;
  logic            w_bad_done;
  logic [WA_W-1:0] w_w_addr;
  logic [IA_W-1:0] w_in_addr;
  logic [OA_W-1:0] w_out_addr;

  assign w_issue   = (r_state == S_FETCH) && en && mm_ready;
  assign w_k_last  = (r_k == K_W'(K - 1));
  assign w_tw_last = (r_tw == TW_W'(NT_W - 1));
  assign w_ti_last = (r_ti == TI_W'(NT_I - 1));
  // A result pulse landing on the same cycle as the WAIT check is consumed directly.
  assign w_wait_go  = (r_state == S_WAIT) && en && (r_pending || mm_done);
  assign w_capture  = mm_done && ((r_state == S_WAIT) || (r_state == S_WRITE));
  assign w_bad_done = mm_done && ((r_state == S_IDLE) || (r_state == S_FETCH) ||
                                  (r_state == S_FIN));

  assign w_w_addr   = WA_W'(r_tw) * WA_W'(K) + WA_W'(r_k);
  assign w_in_addr  = IA_W'(r_ti) * IA_W'(K) + IA_W'(r_k);
  assign w_out_addr = OA_W'(r_ti) * OA_W'(NT_W) + OA_W'(r_tw);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_tw        <= '0;
      r_ti        <= '0;
      r_pending   <= 1'b0;
      r_proto_err <= 1'b0;
      r_ready     <= 1'b1;
      r_done      <= 1'b0;
      r_rd_en     <= 1'b0;
      r_rd_first  <= 1'b0;
      r_rd_last   <= 1'b0;
      r_w_addr    <= '0;
      r_in_addr   <= '0;
      r_mm_valid  <= 1'b0;
      r_mm_first  <= 1'b0;
      r_mm_last   <= 1'b0;
      r_wr_en     <= 1'b0;
      r_out_addr  <= '0;
    end else begin
      r_rd_en <= 1'b0;
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      // One-cycle BRAM latency: beat markers follow the read enable into the array.
      r_mm_valid <= r_rd_en;
      r_mm_first <= r_rd_en && r_rd_first;
      r_mm_last  <= r_rd_en && r_rd_last;

      if (w_bad_done) begin
        r_proto_err <= 1'b1;
      end
      if (w_wait_go) begin
        r_pending <= 1'b0;
      end else if (w_capture) begin
        r_pending <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (en && start) begin
            r_state <= S_FETCH;
            r_ready <= 1'b0;
            r_k     <= '0;
            r_tw    <= '0;
            r_ti    <= '0;
          end
        end
        S_FETCH: begin
          if (w_issue) begin
            r_rd_en    <= 1'b1;
            r_w_addr   <= w_w_addr;
            r_in_addr  <= w_in_addr;
            r_rd_first <= (r_k == '0);
            r_rd_last  <= w_k_last;
            if (w_k_last) begin
              r_k     <= '0;
              r_state <= S_WAIT;
            end else begin
              r_k <= r_k + K_W'(1);
            end
          end
        end
        S_WAIT: begin
          if (w_wait_go) begin
            r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (en) begin
            r_wr_en    <= 1'b1;
            r_out_addr <= w_out_addr;
            if (w_tw_last) begin
              r_tw <= '0;
              if (w_ti_last) begin
                r_state <= S_FIN;
              end else begin
                r_ti    <= r_ti + TI_W'(1);
                r_state <= S_FETCH;
              end
            end else begin
              r_tw    <= r_tw + TW_W'(1);
              r_state <= S_FETCH;
            end
          end
        end
        S_FIN: begin
          if (en) begin
            r_done  <= 1'b1;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ready       = r_ready;
  assign done        = r_done;
  assign w_rd_en     = r_rd_en;
  assign w_rd_addr   = r_w_addr;
  assign in_rd_en    = r_rd_en;
  assign in_rd_addr  = r_in_addr;
  assign mm_valid    = r_mm_valid;
  assign mm_first    = r_mm_first;
  assign mm_last     = r_mm_last;
  assign out_wr_en   = r_wr_en;
  assign out_wr_addr = r_out_addr;
  assign proto_err   = r_proto_err;
  assign dbg_state   = r_state;

endmodule
